axi_lite_master: RTL

- Single-outstanding AXI4-Lite initiator: converts a simple command/response interface into AXI4-Lite read and write transactions.
- Drives the s00_axi_* slave port of peripheral IP (PWM/IRQ cores), replacing bench-side protocol driving with synthesizable RTL.
- Provides a per-transaction watchdog so a hung slave returns an error instead of stalling.

---
 rtl/axi_lite_master_if.sv | 75 +++++++
 rtl/axi_lite_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_if.sv
// Signal bundle for axi_lite_master: command/response side plus the AXI4-Lite bus.
// The master modport is the initiator's view; slave is the view of whatever surrounds it.
interface axi_lite_master_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_wstrb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction out,
// one response back, with a watchdog that turns a hung slave into SLVERR.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic               axi_aclk,
  input logic               axi_reset,
  axi_lite_master_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRITE_RESP, S_READ_ADDR, S_READ_DATA, S_RESP
  } state_t;

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                  r_rsp_valid, r_rsp_timeout;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [31:0]           r_cnt;

  logic w_busy, w_expire, w_phase_done, w_aw_done, w_w_done;

  assign w_busy    = (r_state == S_WRITE) || (r_state == S_WRITE_RESP) ||
                     (r_state == S_READ_ADDR) || (r_state == S_READ_DATA);
  assign w_expire  = (TIMEOUT_CYCLES > 0) && (r_cnt >= TO_LAST);
  assign w_aw_done = !r_awvalid || bus.m_axi_awready;
  assign w_w_done  = !r_wvalid || bus.m_axi_wready;

  // The handshake that ends the current state; it takes priority over watchdog expiry.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_phase_done = 1'b0;
    case (r_state)
      S_WRITE:      w_phase_done = w_aw_done && w_w_done;
      S_WRITE_RESP: w_phase_done = bus.m_axi_bvalid;
      S_READ_ADDR:  w_phase_done = bus.m_axi_arready;
      S_READ_DATA:  w_phase_done = bus.m_axi_rvalid;
      default:      w_phase_done = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; later ones in the same
  // branch override earlier defaults, which the IDLE branch relies on.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_cnt         <= '0;
    end else if (w_busy && w_expire && !w_phase_done) begin
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b1;
      r_rsp_resp    <= 2'b10;
      r_rsp_timeout <= 1'b1;
      r_rsp_rdata   <= '0;
      r_state       <= S_RESP;
    end else begin
      if (w_busy) r_cnt <= r_cnt + 32'd1;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (r_cmd_ready && bus.cmd_valid) begin
            r_cmd_ready   <= 1'b0;
            r_addr        <= bus.cmd_addr;
            r_wdata       <= bus.cmd_wdata;
            r_wstrb       <= bus.cmd_wstrb;
            r_cnt         <= '0;
            r_rsp_timeout <= 1'b0;
            if (bus.cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WRITE;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_READ_ADDR;
            end
          end
        end
        S_WRITE: begin
          if (bus.m_axi_awready) r_awvalid <= 1'b0;
          if (bus.m_axi_wready)  r_wvalid  <= 1'b0;
          if (w_phase_done) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WRITE_RESP;
          end
        end
        S_WRITE_RESP: begin
          if (bus.m_axi_bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= bus.m_axi_bresp;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_READ_ADDR: begin
          if (bus.m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_READ_DATA;
          end
        end
        S_READ_DATA: begin
          if (bus.m_axi_rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= bus.m_axi_rdata;
            r_rsp_resp  <= bus.m_axi_rresp;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_cmd_ready <= 1'b0;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = r_cmd_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.rsp_resp      = r_rsp_resp;
  assign bus.rsp_timeout   = r_rsp_timeout;
  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = r_wstrb;
  assign bus.m_axi_wvalid  = r_wvalid;
  assign bus.m_axi_bready  = r_bready;
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_rready;
endmodule
